// File: rtl/usb_sample_player.sv
// USB sample player: FWFT word FIFO feeding a byte unpacker that emits signed
// 8-bit samples at a programmable rate, with underrun/overflow statistics.
module usb_sample_player #(
    parameter int DEPTH_LOG2  = 6,
    parameter int PRIME_WORDS = 4,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  rate_div,
    input  logic                  underrun_mode,
    input  logic                  clear_stats,
    input  logic [31:0]           usb_rd_data,
    input  logic                  usb_rd_data_valid,
    output logic                  usb_rd_full,
    output logic [7:0]            sample_out,
    output logic                  sample_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic [31:0]           underrun_count,
    output logic                  overflow,
    output logic [1:0]            state_dbg
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] PRIME_LEVEL = (DEPTH_LOG2 + 1)'(PRIME_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIME   = 2'd1,
        PLAY    = 2'd2,
        STARVED = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   count_q, count_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [31:0]            hold_q, hold_d;
    logic [7:0]             sample_q, sample_d;
    logic                   valid_q, valid_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    level_q, level_d;
    logic                   full_q, full_d;
    logic [31:0]            underrun_count_q, underrun_count_d;
    logic                   overflow_q, overflow_d;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] head;
    logic        wr_en;
    logic        pop;
    logic        ur_inc;
    logic        fifo_empty;

    assign head       = mem_q[rd_ptr_q];
    assign fifo_empty = (level_q == '0);
    // Acceptance uses the registered full flag, so a same-cycle pop never rescues a write.
    assign wr_en      = usb_rd_data_valid && !full_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        hold_d     = hold_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        pop        = 1'b0;
        ur_inc     = 1'b0;
        if (!enable) begin
            state_d    = IDLE;
            count_d    = '0;
            byte_idx_d = 2'd0;
            sample_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = PRIME;
                    count_d    = '0;
                    byte_idx_d = 2'd0;
                    sample_d   = 8'd0;
                end
                PRIME: begin
                    if (level_q >= PRIME_LEVEL) state_d = PLAY;
                end
                PLAY: begin
                    if (count_q == '0) begin
                        count_d = rate_div;
                        valid_d = 1'b1;
                        if (byte_idx_q == 2'd0) begin
                            if (!fifo_empty) begin
                                pop        = 1'b1;
                                hold_d     = head;
                                sample_d   = head[7:0];
                                byte_idx_d = 2'd1;
                            end else begin
                                sample_d = underrun_mode ? sample_q : 8'd0;
                                ur_inc   = 1'b1;
                                count_d  = '0;
                                state_d  = STARVED;
                            end
                        end else begin
                            sample_d   = hold_q[{byte_idx_q, 3'b000} +: 8];
                            byte_idx_d = byte_idx_q + 2'd1;
                        end
                    end else begin
                        count_d = count_q - DIV_WIDTH'(1);
                    end
                end
                STARVED: begin
                    count_d = '0;
                    if (level_q >= PRIME_LEVEL) state_d = PLAY;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
            default: level_d = level_q;
        endcase
        full_d = (level_d == FULL_LEVEL);

        underrun_count_d = underrun_count_q;
        if (clear_stats) begin
            underrun_count_d = '0;
        end else if (ur_inc && (underrun_count_q != 32'hFFFF_FFFF)) begin
            underrun_count_d = underrun_count_q + 32'd1;
        end
        overflow_d = clear_stats ? 1'b0 : (overflow_q | (usb_rd_data_valid & full_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            count_q          <= '0;
            byte_idx_q       <= 2'd0;
            hold_q           <= '0;
            sample_q         <= '0;
            valid_q          <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level_q          <= '0;
            full_q           <= 1'b0;
            underrun_count_q <= '0;
            overflow_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            byte_idx_q       <= byte_idx_d;
            hold_q           <= hold_d;
            sample_q         <= sample_d;
            valid_q          <= valid_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            level_q          <= level_d;
            full_q           <= full_d;
            underrun_count_q <= underrun_count_d;
            overflow_q       <= overflow_d;
        end
    end

    // Storage needs no reset: emptiness is defined entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= usb_rd_data;
    end

    assign usb_rd_full    = full_q;
    assign sample_out     = sample_q;
    assign sample_valid   = valid_q;
    assign level          = level_q;
    assign underrun_count = underrun_count_q;
    assign overflow       = overflow_q;
    assign state_dbg      = state_q;

endmodule

// File: doc/usb_sample_player.md
Name: usb_sample_player

Overview:
- Upstream source for the DAC path. Buffers 32-bit sample words arriving from the USB read interface.
- Unpacks each word into four signed 8-bit samples and emits them at a register-programmed rate.
- The output stream feeds the DAC sample mux as an alternative to raw/DDS/ADC data.
- Provides backpressure via a full flag, plus underrun and overflow statistics for software.

Parameters:
DEPTH_LOG2, 6, FIFO depth is 2**DEPTH_LOG2 32-bit words (default 64).
PRIME_WORDS, 4, minimum FIFO level (words) required to start or resume playback; 1 <= PRIME_WORDS <= 2**DEPTH_LOG2.
DIV_WIDTH, 16, width of the sample-rate divider.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
enable  in  1  playback enable.
rate_div  in  DIV_WIDTH  sample period is rate_div+1 clk cycles.
underrun_mode  in  1  behaviour on underrun: 0 = emit zero, 1 = repeat last sample.
clear_stats  in  1  synchronous pulse; clears underrun_count and overflow.
usb_rd_data  in  32  packed samples; byte0 = bits[7:0] is played first.
usb_rd_data_valid  in  1  write strobe for usb_rd_data.
usb_rd_full  out  1  FIFO full (level == 2**DEPTH_LOG2).
sample_out  out  8  signed output sample, registered.
sample_valid  out  1  one-cycle strobe per emitted sample.
level  out  DEPTH_LOG2+1  current FIFO occupancy in words.
underrun_count  out  32  saturating underrun event count.
overflow  out  1  sticky flag: a write was dropped.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs return to 0, FIFO is emptied, state = IDLE, byte_idx = 0, divider count = 0.
- FIFO writes:
  - A write is accepted when usb_rd_data_valid=1 and the registered usb_rd_full=0.
  - A write while full is dropped and sets overflow=1, even if a pop occurs in the same cycle.
- FIFO reads and level:
  - The FIFO is first-word-fall-through: the head word is readable combinationally.
  - level and usb_rd_full are registered and update on the edge after a write or pop.
  - A simultaneous accepted write and pop leaves level unchanged.
- Writes are accepted in every state, so software can pre-fill the FIFO while enable=0.
- States:
  - IDLE: sample_out=0, sample_valid=0, divider held at 0, byte_idx=0. Moves to PRIME when enable=1.
  - PRIME: no output. Moves to PLAY on the edge where level >= PRIME_WORDS.
  - PLAY: the divider runs. tick = (count==0); on tick, count <= rate_div, otherwise count <= count-1. count is 0 on entry, so the first tick falls in the first PLAY cycle.
  - STARVED: divider held at 0, no output. Moves to PLAY when level >= PRIME_WORDS.
  - Any state goes to IDLE when enable=0. On that transition the partially played word is discarded, byte_idx is set to 0, and the FIFO contents are retained.
- Tick in PLAY with byte_idx==0 and FIFO non-empty:
  - Pops the head word into the hold register.
  - Emits its byte0.
  - Sets byte_idx <= 1.
- Tick in PLAY with byte_idx = 1..3:
  - Emits the corresponding byte of the hold register.
  - byte_idx increments and wraps 3 -> 0.
- Tick in PLAY with byte_idx==0 and FIFO empty (underrun):
  - Emits 0 (underrun_mode=0) or the previous sample_out (underrun_mode=1), with sample_valid=1.
  - underrun_count increments, saturating at 0xFFFFFFFF.
  - State goes to STARVED.
- Output latency: a tick in cycle N drives sample_out and sample_valid on the edge ending cycle N. sample_valid is 0 in all non-tick cycles, and sample_out holds its last value between ticks.
- rate_div=0 gives one sample per cycle. rate_div changes take effect at the next tick reload.
- clear_stats has priority over a same-cycle underrun increment or overflow set; the result is cleared.
- Arithmetic: samples are two's-complement bytes passed through unchanged. There is no gain or clamping in this block.

Test Plan:
1. Reset asserted mid-PLAY -> immediately sample_out=0, sample_valid=0, level=0, usb_rd_full=0, underrun_count=0.
2. Write 0x04030201 and 0x88776655, plus 2 pad words, with enable=0; then enable=1, rate_div=0, underrun_mode=0:
   - sample_valid high for 16 consecutive cycles.
   - First samples are 0x01,0x02,0x03,0x04,0x55,0x66,0x77,0x88.
   - The 17th tick emits 0x00, underrun_count=1, state STARVED.
3. rate_div=3 with 8 words buffered -> sample_valid pulses exactly every 4th cycle; 32 samples, then one underrun.
4. enable=0, write 65 words -> usb_rd_full=1 at level=64, the 65th word is dropped, overflow=1. Then clear_stats pulse -> overflow=0 and underrun_count=0.
5. underrun_mode=1, last played word 0x80xxxxxx -> the underrun tick emits 0x80 (-128) with sample_valid=1. Then write 4 words -> playback resumes after level reaches 4.
6. Simultaneous write and pop at level=3 -> level stays 3. Drop enable mid-word after byte1 -> re-enable restarts at byte0 of the next FIFO word.
